// File: rtl/vector_cache_pkg.sv
// Shared widths for the vector cache write path.
package vector_cache_pkg;
  parameter int TXNID_WIDTH        = 8;
  parameter int SIDEBAND_WIDTH     = 4;
  parameter int DB_ENTRY_IDX_WIDTH = 5;
endpackage

// File: rtl/write_rsp_xbar_if.sv
// Bundle of bank response, requester ack and buffer-free signals around the
// write response crossbar. "slave" is the crossbar side, "master" the
// surrounding banks/requesters/allocator.
interface write_rsp_xbar_if #(
  parameter int W_REQ_NUM = 8,
  parameter int SRC_W     = $clog2(W_REQ_NUM)
) ();
  localparam int TW = vector_cache_pkg::TXNID_WIDTH;
  localparam int SW = vector_cache_pkg::SIDEBAND_WIDTH;
  localparam int DW = vector_cache_pkg::DB_ENTRY_IDX_WIDTH;

  logic [3:0]                    wr_rsp_vld;
  logic [3:0]                    wr_rsp_rdy;
  logic [3:0][SRC_W-1:0]         wr_rsp_src_id;
  logic [3:0][TW-1:0]            wr_rsp_txnid;
  logic [3:0][SW-1:0]            wr_rsp_sideband;
  logic [3:0][DW-1:0]            wr_rsp_db_entry_id;
  logic [W_REQ_NUM-1:0]          wr_ack_vld;
  logic [W_REQ_NUM-1:0]          wr_ack_rdy;
  logic [W_REQ_NUM-1:0][TW-1:0]  wr_ack_txnid;
  logic [W_REQ_NUM-1:0][SW-1:0]  wr_ack_sideband;
  logic [3:0]                    free_vld;
  logic [3:0][DW-1:0]            free_idx;
  logic                          err_src_oob;

  modport slave (
    input  wr_rsp_vld, wr_rsp_src_id, wr_rsp_txnid, wr_rsp_sideband,
           wr_rsp_db_entry_id, wr_ack_rdy,
    output wr_rsp_rdy, wr_ack_vld, wr_ack_txnid, wr_ack_sideband,
           free_vld, free_idx, err_src_oob
  );

  modport master (
    output wr_rsp_vld, wr_rsp_src_id, wr_rsp_txnid, wr_rsp_sideband,
           wr_rsp_db_entry_id, wr_ack_rdy,
    input  wr_rsp_rdy, wr_ack_vld, wr_ack_txnid, wr_ack_sideband,
           free_vld, free_idx, err_src_oob
  );
endinterface

// File: rtl/write_rsp_xbar.sv
// Write response return crossbar: routes bank write completions to the
// originating requester port (1-deep register + round-robin per port) and
// pulses the consumed write-data-buffer entry back to the allocator.
// Optional feature macro: WR_RSP_XBAR_SRC_CHK_EN (accept and flag
// out-of-range src_id instead of stalling the bank).
module write_rsp_xbar
  import vector_cache_pkg::*;
#(
  parameter int W_REQ_NUM = 8,
  parameter int SRC_W     = $clog2(W_REQ_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  write_rsp_xbar_if.slave  rsp
);
  localparam int NB = 4;

  // Per-port one-hot of the bank accepted this cycle.
  logic [W_REQ_NUM-1:0][NB-1:0]       w_gnt;
  logic [NB-1:0]                      w_accept;
  logic [NB-1:0]                      w_rdy;
  logic [NB-1:0]                      r_free_vld;
  logic [NB-1:0][DB_ENTRY_IDX_WIDTH-1:0] r_free_idx;

  genvar gi;
  generate
    for (gi = 0; gi < W_REQ_NUM; gi++) begin : g_port
      logic                      r_full;
      logic [TXNID_WIDTH-1:0]    r_txnid;
      logic [SIDEBAND_WIDTH-1:0] r_sideband;
      logic [1:0]                r_rr_ptr;
      logic [NB-1:0]             w_req;
      logic                      w_can_load;
      logic                      w_any;
      logic [1:0]                w_win;

      // Which banks currently address this port.
      always_comb begin
        for (int b = 0; b < NB; b++) begin
          w_req[b] = rsp.wr_rsp_vld[b] && (int'(rsp.wr_rsp_src_id[b]) == gi);
        end
      end

      // The register can take a new response if empty or draining this cycle.
      assign w_can_load = !r_full || rsp.wr_ack_rdy[gi];

      // Round-robin pick: first requester at or after the pointer, wrapping.
      always_comb begin
        w_any = 1'b0;
        w_win = r_rr_ptr;
        for (int k = 0; k < NB; k++) begin
          if (!w_any && w_req[r_rr_ptr + 2'(k)]) begin
            w_any = 1'b1;
            w_win = r_rr_ptr + 2'(k);
          end
        end
      end

      assign w_gnt[gi] = (w_any && w_can_load) ? (4'b0001 << w_win) : 4'b0000;

      // Output register and pointer: load on grant, clear on drain otherwise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_full     <= 1'b0;
          r_txnid    <= '0;
          r_sideband <= '0;
          r_rr_ptr   <= 2'd0;
        end else if (w_any && w_can_load) begin
          r_full     <= 1'b1;
          r_txnid    <= rsp.wr_rsp_txnid[w_win];
          r_sideband <= rsp.wr_rsp_sideband[w_win];
          r_rr_ptr   <= w_win + 2'd1;
        end else if (rsp.wr_ack_rdy[gi]) begin
          r_full     <= 1'b0;
        end
      end

      assign rsp.wr_ack_vld[gi]      = r_full;
      assign rsp.wr_ack_txnid[gi]    = r_txnid;
      assign rsp.wr_ack_sideband[gi] = r_sideband;
    end
  endgenerate

  // A bank is accepted if it won at whichever port it addressed.
  always_comb begin
    w_accept = '0;
    for (int r = 0; r < W_REQ_NUM; r++) begin
      for (int b = 0; b < NB; b++) begin
        w_accept[b] = w_accept[b] | w_gnt[r][b];
      end
    end
  end

`ifdef WR_RSP_XBAR_SRC_CHK_EN
  logic [NB-1:0] w_oob;
  logic          r_err;

  // Out-of-range destinations are swallowed so their buffer entry still frees.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      w_oob[b] = rsp.wr_rsp_vld[b] && (int'(rsp.wr_rsp_src_id[b]) >= W_REQ_NUM);
    end
  end

  assign w_rdy = w_accept | w_oob;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (|w_oob) begin
      r_err <= 1'b1;
    end
  end

  assign rsp.err_src_oob = r_err;
`else
  assign w_rdy           = w_accept;
  assign rsp.err_src_oob = 1'b0;
`endif

  assign rsp.wr_rsp_rdy = w_rdy;

  // One-cycle free pulse per accepted bank, independent of ack backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_free_vld <= '0;
      r_free_idx <= '0;
    end else begin
      r_free_vld <= w_rdy;
      for (int b = 0; b < NB; b++) begin
        if (w_rdy[b]) begin
          r_free_idx[b] <= rsp.wr_rsp_db_entry_id[b];
        end
      end
    end
  end

  assign rsp.free_vld = r_free_vld;
  assign rsp.free_idx = r_free_idx;
endmodule

// File: tb/tb_write_rsp_xbar.sv
// Directed + random bench for write_rsp_xbar against a cycle-level
// behavioural model of the routing/arbitration rules.
module tb_write_rsp_xbar;
  import vector_cache_pkg::*;
`ifdef WR_RSP_XBAR_SRC_CHK_EN
  localparam int W = 6;
`else
  localparam int W = 8;
`endif
  localparam int SW = $clog2(W);
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  write_rsp_xbar_if #(.W_REQ_NUM(W)) xif ();
  write_rsp_xbar #(.W_REQ_NUM(W)) dut (.clk(clk), .rst(rst), .rsp(xif.slave));

  // Behavioural model state
  bit                           m_full [W];
  logic [TXNID_WIDTH-1:0]       m_txn  [W];
  logic [SIDEBAND_WIDTH-1:0]    m_sb   [W];
  int                           m_ptr  [W];
  bit                           m_fv   [NB];
  logic [DB_ENTRY_IDX_WIDTH-1:0] m_fi  [NB];
  bit                           m_err;
  // Decisions computed for the current cycle
  int                           p_win  [W];
  logic [TXNID_WIDTH-1:0]       p_txn  [W];
  logic [SIDEBAND_WIDTH-1:0]    p_sb   [W];
  logic [NB-1:0]                p_acc;
  logic [DB_ENTRY_IDX_WIDTH-1:0] p_db  [NB];
  bit                           p_oob;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < W; r++) begin
      m_full[r] = 0; m_txn[r] = '0; m_sb[r] = '0; m_ptr[r] = 0;
    end
    for (int b = 0; b < NB; b++) begin
      m_fv[b] = 0; m_fi[b] = '0;
    end
    m_err = 0;
  endtask

  task automatic bank(input int b, input bit v, input int src, input int txn,
                      input int sb, input int db);
    xif.wr_rsp_vld[b]         = v;
    xif.wr_rsp_src_id[b]      = SW'(src);
    xif.wr_rsp_txnid[b]       = TXNID_WIDTH'(txn);
    xif.wr_rsp_sideband[b]    = SIDEBAND_WIDTH'(sb);
    xif.wr_rsp_db_entry_id[b] = DB_ENTRY_IDX_WIDTH'(db);
  endtask

  task automatic idle_banks();
    for (int b = 0; b < NB; b++) bank(b, 0, 0, 0, 0, 0);
  endtask

  // At the falling edge: predict acceptance and compare every output.
  task automatic check_phase();
    logic [W-1:0]  av;
    logic [NB-1:0] fv;
    @(negedge clk);
    p_acc = '0;
    p_oob = 0;
    for (int r = 0; r < W; r++) begin
      p_win[r] = -1;
      if (!m_full[r] || xif.wr_ack_rdy[r]) begin
        for (int k = 0; k < NB; k++) begin
          int b;
          b = (m_ptr[r] + k) % NB;
          if (p_win[r] < 0 && xif.wr_rsp_vld[b] && int'(xif.wr_rsp_src_id[b]) == r) begin
            p_win[r] = b;
            p_txn[r] = xif.wr_rsp_txnid[b];
            p_sb[r]  = xif.wr_rsp_sideband[b];
            p_acc[b] = 1'b1;
          end
        end
      end
    end
`ifdef WR_RSP_XBAR_SRC_CHK_EN
    for (int b = 0; b < NB; b++) begin
      if (xif.wr_rsp_vld[b] && int'(xif.wr_rsp_src_id[b]) >= W) begin
        p_acc[b] = 1'b1;
        p_oob = 1;
      end
    end
`endif
    for (int b = 0; b < NB; b++) p_db[b] = xif.wr_rsp_db_entry_id[b];
    chk("rsp_rdy", xif.wr_rsp_rdy, p_acc);
    for (int r = 0; r < W; r++) av[r] = m_full[r];
    chk("ack_vld", xif.wr_ack_vld, av);
    for (int r = 0; r < W; r++) begin
      if (m_full[r]) begin
        chk($sformatf("ack_txnid[%0d]", r), xif.wr_ack_txnid[r], m_txn[r]);
        chk($sformatf("ack_sb[%0d]", r), xif.wr_ack_sideband[r], m_sb[r]);
      end
    end
    for (int b = 0; b < NB; b++) fv[b] = m_fv[b];
    chk("free_vld", xif.free_vld, fv);
    for (int b = 0; b < NB; b++) begin
      if (m_fv[b]) chk($sformatf("free_idx[%0d]", b), xif.free_idx[b], m_fi[b]);
    end
    chk("err_src_oob", xif.err_src_oob, m_err);
  endtask

  // Cross the rising edge and apply the predicted transitions.
  task automatic adv();
    @(posedge clk);
    #1;
    for (int r = 0; r < W; r++) begin
      if (p_win[r] >= 0) begin
        m_full[r] = 1; m_txn[r] = p_txn[r]; m_sb[r] = p_sb[r];
        m_ptr[r] = (p_win[r] + 1) % NB;
      end else if (xif.wr_ack_rdy[r]) begin
        m_full[r] = 0;
      end
    end
    for (int b = 0; b < NB; b++) begin
      m_fv[b] = p_acc[b];
      if (p_acc[b]) m_fi[b] = p_db[b];
    end
    if (p_oob) m_err = 1;
  endtask

  task automatic cyc();
    check_phase();
    adv();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack_vld"}, xif.wr_ack_vld, '0);
    chk({tag, "_free_vld"}, xif.free_vld, '0);
    chk({tag, "_err"}, xif.err_src_oob, 1'b0);
    chk({tag, "_txnid"}, 64'(xif.wr_ack_txnid), '0);
    chk({tag, "_sb"}, 64'(xif.wr_ack_sideband), '0);
    chk({tag, "_free_idx"}, 64'(xif.free_idx), '0);
  endtask

  initial begin
    logic [W-1:0] mask;
    int dst [NB];
    idle_banks();
    xif.wr_ack_rdy = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single response
    bank(2, 1, 5, 'h1A, 3, 7);
    check_phase();
    chk("single_rdy", xif.wr_rsp_rdy, 4'b0100);
    adv();
    idle_banks();
    chk("single_ack_vld5", xif.wr_ack_vld[5], 1'b1);
    chk("single_txnid5", xif.wr_ack_txnid[5], 'h1A);
    chk("single_free_vld", xif.free_vld, 4'b0100);
    chk("single_free_idx2", xif.free_idx[2], 7);
    cyc();
    chk("single_free_end", xif.free_vld, 4'b0000);

    // Contention: all banks to port 3, round-robin 0,1,2,3 then back to 0
    for (int b = 0; b < NB; b++) bank(b, 1, 3, 'h30 + b, b, b + 8);
    for (int k = 0; k < 5; k++) begin
      check_phase();
      chk($sformatf("cont_rdy_%0d", k), xif.wr_rsp_rdy, 4'b0001 << (k % 4));
      adv();
      chk($sformatf("cont_txnid_%0d", k), xif.wr_ack_txnid[3], 'h30 + (k % 4));
    end
    idle_banks();
    cyc();

    // Backpressure on port 1, port 6 unaffected
    xif.wr_ack_rdy[1] = 1'b0;
    bank(0, 1, 1, 'hA5, 5, 3);
    cyc();
    bank(0, 1, 1, 'hB6, 6, 4);
    bank(1, 1, 6, 'hC7, 7, 9);
    for (int i = 0; i < 5; i++) begin
      check_phase();
      chk("bp_rdy0", xif.wr_rsp_rdy[0], 1'b0);
      if (i == 0) chk("bp_rdy1", xif.wr_rsp_rdy[1], 1'b1);
      adv();
      if (i == 0) bank(1, 0, 0, 0, 0, 0);
      chk("bp_hold_txnid1", xif.wr_ack_txnid[1], 'hA5);
      chk("bp_hold_vld1", xif.wr_ack_vld[1], 1'b1);
    end
    xif.wr_ack_rdy[1] = 1'b1;
    check_phase();
    chk("bp_release_rdy0", xif.wr_rsp_rdy[0], 1'b1);
    adv();
    chk("bp_reload_txnid1", xif.wr_ack_txnid[1], 'hB6);
    idle_banks();
    cyc();
    cyc();

    // Parallel: four distinct ports in one cycle
    dst[0] = 0; dst[1] = 2; dst[2] = 4; dst[3] = W - 1;
    mask = '0;
    for (int b = 0; b < NB; b++) begin
      bank(b, 1, dst[b], 'h50 + b, b, 20 + b);
      mask[dst[b]] = 1'b1;
    end
    check_phase();
    chk("par_rdy", xif.wr_rsp_rdy, 4'b1111);
    adv();
    idle_banks();
    chk("par_ack_vld", xif.wr_ack_vld, mask);
    chk("par_free_vld", xif.free_vld, 4'b1111);
    cyc();

`ifdef WR_RSP_XBAR_SRC_CHK_EN
    // Out-of-range destination is swallowed and flagged
    bank(1, 1, 7, 'h77, 1, 17);
    check_phase();
    chk("oob_rdy1", xif.wr_rsp_rdy[1], 1'b1);
    adv();
    idle_banks();
    chk("oob_no_ack", xif.wr_ack_vld, '0);
    chk("oob_free_vld", xif.free_vld, 4'b0010);
    chk("oob_free_idx1", xif.free_idx[1], 17);
    chk("oob_err", xif.err_src_oob, 1'b1);
    repeat (3) cyc();
    chk("oob_err_sticky", xif.err_src_oob, 1'b1);
`endif

    // Asynchronous reset with acks and frees in flight
    xif.wr_ack_rdy = '0;
    bank(0, 1, 0, 'h61, 1, 1);
    bank(1, 1, 4, 'h62, 2, 2);
    bank(2, 1, 2, 'h63, 3, 3);
    cyc();
    idle_banks();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    xif.wr_ack_rdy = '1;
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) bank(b, 1, 2, 'h70 + b, b, b);
    check_phase();
    chk("rst_rr_order", xif.wr_rsp_rdy, 4'b0001);
    adv();
    idle_banks();
    cyc();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < NB; b++) begin
        int src;
        src = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 2)
                                           : $urandom_range(0, (1 << SW) - 1);
        bank(b, bit'($urandom_range(0, 1)), src, $urandom, $urandom, $urandom);
      end
      xif.wr_ack_rdy = W'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_rsp_xbar.md
# write_rsp_xbar

Return-path crossbar for vector cache writes. It takes write-completion responses from the 4 bank channels, routes each one to the originating write requester port, and returns the consumed write-data-buffer entry index to the allocator. It sits between the 4 bank write pipelines and the W_REQ_NUM requester ports, mirroring the 4-way write request crossbar on the request side.

## Interface
- `W_REQ_NUM`, 8, number of requester ports.
- `SRC_W`, `$clog2(W_REQ_NUM)`, width of the requester id.
- Widths `TXNID_WIDTH`, `SIDEBAND_WIDTH` and `DB_ENTRY_IDX_WIDTH` come from `vector_cache_pkg`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_rsp_vld`  in  [3:0]  bank response valid.
- `wr_rsp_rdy`  out  [3:0]  bank response accepted this cycle.
- `wr_rsp_src_id`  in  [SRC_W-1:0] x4  destination requester index.
- `wr_rsp_txnid`  in  [TXNID_WIDTH-1:0] x4  transaction id echoed to the requester.
- `wr_rsp_sideband`  in  [SIDEBAND_WIDTH-1:0] x4  sideband echoed to the requester.
- `wr_rsp_db_entry_id`  in  [DB_ENTRY_IDX_WIDTH-1:0] x4  write data buffer entry to free.
- `wr_ack_vld`  out  [W_REQ_NUM-1:0]  per-requester ack valid.
- `wr_ack_rdy`  in  [W_REQ_NUM-1:0]  requester ready.
- `wr_ack_txnid`  out  [TXNID_WIDTH-1:0] x W_REQ_NUM.
- `wr_ack_sideband`  out  [SIDEBAND_WIDTH-1:0] x W_REQ_NUM.
- `free_vld`  out  [3:0]  one-cycle pulse; the buffer entry of bank b is released.
- `free_idx`  out  [DB_ENTRY_IDX_WIDTH-1:0] x4  index of the released entry.
- `err_src_oob`  out  1  sticky out-of-range `src_id` flag (see Configuration).

## Operation
- Each requester port r has a 1-deep output register (`ack_full[r]`, txnid, sideband) and a 2-bit round-robin pointer `rr_ptr[r]`.
- Request matrix: bank b requests port r when `wr_rsp_vld[b]` is high and `wr_rsp_src_id[b]==r`.
- Per-port arbitration:
  - A port can load when `!ack_full[r] || wr_ack_rdy[r]`.
  - The winner is the first requesting bank at or after `rr_ptr[r]`, searching in ascending index with wrap.
- `wr_rsp_rdy[b]` is high only when bank b wins at its destination port and that port can load. It is purely combinational from registers and inputs.
- On accept:
  - The port register loads the bank's txnid and sideband.
  - `rr_ptr[r]` moves to winner+1 (mod 4). The pointer does not move when there is no grant.
- Free path:
  - Each accepted bank response registers `free_vld[b]=1` and `free_idx[b]=wr_rsp_db_entry_id[b]` for exactly one cycle.
  - The free fires independently of requester backpressure.
  - Up to 4 frees per cycle (one per bank).
- Different destination ports are independent, so up to 4 banks can be accepted per cycle when their `src_id` values differ.
- Payload on `wr_ack_txnid` and `wr_ack_sideband` holds stable while `wr_ack_vld` is high and `wr_ack_rdy` is low.

## Timing
- Reset values:
  - `wr_ack_vld` = 0, `free_vld` = 0, `err_src_oob` = 0.
  - Payload registers = 0, `free_idx` = 0.
  - `rr_ptr` = 0 for all ports.
- Latency: 1 cycle from the accept edge to `wr_ack_vld[r]` and to `free_vld[b]`.
- Throughput: 1 ack per port per cycle when a full register drains and reloads in the same cycle (`wr_ack_rdy` high while full).
- Full with `wr_ack_rdy` low: every bank targeting that port sees `wr_rsp_rdy=0`. Other ports are unaffected.
- Reset asserted mid-operation: in-flight acks and pending frees are dropped. The upstream allocator is reset in the same domain.

## Configuration
- Macro: `WR_RSP_XBAR_SRC_CHK_EN`.
- Defined:
  - A bank with `wr_rsp_src_id >= W_REQ_NUM` is accepted unconditionally (`wr_rsp_rdy[b]=1`).
  - No ack is produced.
  - `free_vld[b]` still pulses, so the buffer entry is not leaked.
  - `err_src_oob` sets the next cycle and stays set until reset.
- Undefined:
  - `err_src_oob` is tied to 0.
  - An out-of-range `src_id` gets no grant and `wr_rsp_rdy[b]` stays 0, so the bank stalls.
  - With a power-of-two `W_REQ_NUM` this case cannot occur.

## Test plan
- Single response: bank 2 sends `src_id=5`, txnid 0x1A, `db_entry_id` 7, with `wr_ack_rdy=1`. Next cycle `wr_ack_vld[5]=1` with txnid 0x1A, and `free_vld[2]=1` with `free_idx[2]=7` for one cycle.
- Contention: banks 0–3 all send `src_id=3`, held valid with ready high. Grants go in order 0,1,2,3 on consecutive cycles, one ack per cycle, and `rr_ptr[3]` returns to 0.
- Backpressure: port 1 is full and `wr_ack_rdy[1]=0` for 5 cycles while bank 0 targets port 1 and bank 1 targets port 6. `wr_rsp_rdy[0]=0` for all 5 cycles, bank 1 is accepted immediately, and the port 1 payload holds stable.
- Parallel: banks 0–3 target ports 0, 2, 4, 7 in the same cycle. All four `wr_rsp_rdy` are high, all four acks appear the next cycle, and all four frees pulse together.
- Reset: assert `rst` while ports 0 and 4 hold acks. All outputs go to 0 asynchronously, and the first response after release wins from bank 0 pointer order.
- With `WR_RSP_XBAR_SRC_CHK_EN` and `W_REQ_NUM=6`: bank 1 sends `src_id=7`. It is accepted, no ack appears, `free_vld[1]` pulses, and `err_src_oob` stays at 1 until reset.
